fifo36_to_ll8: RTL and testbench
================================

FIFO36_TO_LL8 -- requirements
Module: fifo36_to_ll8

Interface
REQ-001 Parameter: BIG_ENDIAN, default 1, 1 = byte f36_data[31:24] sent first; 0 = byte f36_data[7:0] sent first.
REQ-002 clk  input  1  clock; all logic rising-edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 clear  input  1  synchronous flush, active-high.
REQ-005 f36_data  input  36  {occ[1:0], eof, sof, data[31:0]}.
REQ-006 f36_src_rdy_i  input  1  upstream word valid.
REQ-007 f36_dst_rdy_o  output  1  block accepts word.
REQ-008 ll_data  output  8  LocalLink byte.
REQ-009 ll_sof_n  output  1  start of frame, active-low.
REQ-010 ll_eof_n  output  1  end of frame, active-low.
REQ-011 ll_src_rdy_n  output  1  byte valid, active-low.
REQ-012 ll_dst_rdy_n  input  1  downstream ready, active-low.
REQ-013 err  output  1  sticky protocol error flag.

Function
REQ-014 Word transfer when f36_src_rdy_i & f36_dst_rdy_o; byte transfer (bxfer) when ~ll_src_rdy_n & ~ll_dst_rdy_n.
REQ-015 One-word holding register with valid flag and 2-bit byte index idx; word captured into it on word transfer, idx set to 0.
REQ-016 Last index: occ==0 or eof==0 -> 3; eof==1 and occ=1/2/3 -> 0/1/2.
REQ-017 f36_dst_rdy_o = ~valid | (bxfer & idx==last); no bubble cycle between consecutive words.
REQ-018 On bxfer with idx!=last: idx increments; with idx==last and no new word: valid clears.
REQ-019 ll_src_rdy_n = ~valid; ll_data = byte idx of held word per BIG_ENDIAN.
REQ-020 ll_sof_n = ~(valid & sof & idx==0); ll_eof_n = ~(valid & eof & idx==last).
REQ-021 Latency: word accepted at edge N -> first byte presented after edge N; full word drains in 4 cycles with ll_dst_rdy_n held low.
REQ-022 Stall: ll_dst_rdy_n high holds ll_data, sof, eof, idx unchanged indefinitely.
REQ-023 occ ignored when eof==0; bytes beyond last never emitted.
REQ-024 Single-word packet (sof & eof, occ=1) yields one byte with sof and eof asserted together.

Reset
REQ-025 reset or clear: valid=0, idx=0, err=0; thus ll_src_rdy_n=1, ll_sof_n=1, ll_eof_n=1, f36_dst_rdy_o=1 next cycle.
REQ-026 Reset mid-packet discards the held word; no partial byte output after reset deasserts; first accepted word after reset starts clean.
REQ-027 Holding-data register need not be reset; ll_data is don't-care while ll_src_rdy_n=1.

Configuration
REQ-028 Macro FIFO36_TO_LL8_ERR_CHECK_EN: when defined, a 1-bit in_pkt tracker sets err on word accept with sof=1 while in_pkt=1, or sof=0 while in_pkt=0; err sticky until reset/clear; data still forwarded unchanged.
REQ-029 Without the macro: no tracker logic, err tied to 0.

Structure
REQ-030 Shared package holds field positions of the 36-bit word (OCC_HI=35, OCC_LO=34, EOF_BIT=33, SOF_BIT=32) and OCC_FULL=2'd0.
REQ-031 Single flat module; no sub-module; companion to ll8_to_fifo36 so loopback ll8->f36->ll8 is bit-exact.

Verification
REQ-032 One word 0xA1B2C3D4, sof=1, eof=1, occ=0, ll_dst_rdy_n=0 -> bytes A1,B2,C3,D4 on 4 consecutive cycles; sof on A1, eof on D4.
REQ-033 Two-word packet, second word occ=2 data 0x55660000 -> 6 bytes, last two 55,66, eof on 66, f36_dst_rdy_o high on byte-3 cycle.
REQ-034 ll_dst_rdy_n toggled random 50% -> output byte sequence identical to REQ-032, outputs stable during stalls.
REQ-035 BIG_ENDIAN=0, word 0xA1B2C3D4 -> D4,C3,B2,A1.
REQ-036 Reset asserted after second byte of 4-byte word -> ll_src_rdy_n=1 next cycle, next packet emitted from its first byte with sof.
REQ-037 With FIFO36_TO_LL8_ERR_CHECK_EN: two sof words without eof between -> err=1 after second accept, stays 1 until clear; without macro err=0.

Source files
------------

// File: rtl/fifo36_to_ll8_pkg.sv
// fifo36_to_ll8_pkg
//   Shared field layout of the 36-bit FIFO word {occ[1:0], eof, sof, data[31:0]}
//   and a helper that maps (occ, eof) to the index of the last valid byte.
//   Imported by fifo36_to_ll8.
package fifo36_to_ll8_pkg;

  localparam int unsigned OCC_HI  = 35;
  localparam int unsigned OCC_LO  = 34;
  localparam int unsigned EOF_BIT = 33;
  localparam int unsigned SOF_BIT = 32;

  // occ == 0 means all four bytes of the word are valid
  localparam logic [1:0] OCC_FULL = 2'd0;

  // occ only qualifies the final word of a frame; mid-frame words are always full
  function automatic logic [1:0] last_idx(input logic [1:0] occ, input logic eof);
    if (!eof || occ == OCC_FULL) begin
      return 2'd3;
    end
    return occ - 2'd1;
  endfunction

endpackage

// File: rtl/fifo36_to_ll8.sv
// fifo36_to_ll8
//   Serialises 36-bit FIFO words {occ, eof, sof, data[31:0]} into an 8-bit
//   LocalLink byte stream. One word is held at a time; the next word is
//   accepted on the same cycle the last byte of the held word leaves, so a
//   continuous stream has no bubble cycles.
//
// Parameters
//   BIG_ENDIAN     1: data[31:24] first, 0: data[7:0] first
//
// Ports
//   clk            clock, rising edge
//   reset          synchronous, active-high
//   clear          synchronous flush, active-high
//   f36_data       {occ[1:0], eof, sof, data[31:0]}
//   f36_src_rdy_i  upstream word valid
//   f36_dst_rdy_o  block can accept a word this cycle
//   ll_data        LocalLink byte
//   ll_sof_n       start of frame, active-low
//   ll_eof_n       end of frame, active-low
//   ll_src_rdy_n   byte valid, active-low
//   ll_dst_rdy_n   downstream ready, active-low
//   err            sticky framing error flag
//
// Build option
//   FIFO36_TO_LL8_ERR_CHECK_EN  enables sof/eof framing tracker driving err;
//                               when undefined err is tied low.
module fifo36_to_ll8
  import fifo36_to_ll8_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [35:0] f36_data,
  input  logic        f36_src_rdy_i,
  output logic        f36_dst_rdy_o,
  output logic [7:0]  ll_data,
  output logic        ll_sof_n,
  output logic        ll_eof_n,
  output logic        ll_src_rdy_n,
  input  logic        ll_dst_rdy_n,
  output logic        err
);

  logic [35:0] hold;
  logic        valid;
  logic [1:0]  idx;
  logic [1:0]  last;
  logic [1:0]  lane;
  logic        at_last;
  logic        bxfer;
  logic        wxfer;

  assign last    = last_idx(hold[OCC_HI:OCC_LO], hold[EOF_BIT]);
  assign at_last = (idx == last);
  assign bxfer   = valid & ~ll_dst_rdy_n;

  // Ready while empty, or when the final byte leaves this cycle
  assign f36_dst_rdy_o = ~valid | (bxfer & at_last);
  assign wxfer         = f36_src_rdy_i & f36_dst_rdy_o;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
      idx   <= '0;
    end else if (wxfer) begin
      valid <= 1'b1;
      idx   <= '0;
    end else if (bxfer) begin
      if (at_last) begin
        valid <= 1'b0;
        idx   <= '0;
      end else begin
        idx <= idx + 2'd1;
      end
    end
  end

  // Payload is qualified by valid, so it carries no reset
  always_ff @(posedge clk) begin
    if (wxfer) begin
      hold <= f36_data;
    end
  end

  // Big-endian walks lanes 3..0, little-endian 0..3
  assign lane = (BIG_ENDIAN != 0) ? ~idx : idx;

  always_comb begin
    ll_data = hold[7:0];
    unique case (lane)
      2'd0: ll_data = hold[7:0];
      2'd1: ll_data = hold[15:8];
      2'd2: ll_data = hold[23:16];
      2'd3: ll_data = hold[31:24];
      default: ll_data = hold[7:0];
    endcase
  end

  assign ll_src_rdy_n = ~valid;
  assign ll_sof_n     = ~(valid & hold[SOF_BIT] & (idx == 2'd0));
  assign ll_eof_n     = ~(valid & hold[EOF_BIT] & at_last);

`ifdef FIFO36_TO_LL8_ERR_CHECK_EN
  logic in_pkt;

  // A sof word must open a frame and a non-sof word must continue one
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      in_pkt <= 1'b0;
      err    <= 1'b0;
    end else if (wxfer) begin
      in_pkt <= ~f36_data[EOF_BIT];
      if (f36_data[SOF_BIT] == in_pkt) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo36_to_ll8.sv
module tb_fifo36_to_ll8;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [35:0] f36_data;
  logic        f36_src_rdy_i;
  logic        ll_dst_rdy_n;

  logic        f36_dst_rdy_o, ll_sof_n, ll_eof_n, ll_src_rdy_n, err;
  logic [7:0]  ll_data;
  logic        le_f36_dst_rdy_o, le_ll_sof_n, le_ll_eof_n, le_ll_src_rdy_n, le_err;
  logic [7:0]  le_ll_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo36_to_ll8 dut (
    .clk(clk), .reset(reset), .clear(clear),
    .f36_data(f36_data), .f36_src_rdy_i(f36_src_rdy_i), .f36_dst_rdy_o(f36_dst_rdy_o),
    .ll_data(ll_data), .ll_sof_n(ll_sof_n), .ll_eof_n(ll_eof_n),
    .ll_src_rdy_n(ll_src_rdy_n), .ll_dst_rdy_n(ll_dst_rdy_n), .err(err)
  );

  fifo36_to_ll8 #(.BIG_ENDIAN(0)) dut_le (
    .clk(clk), .reset(reset), .clear(clear),
    .f36_data(f36_data), .f36_src_rdy_i(f36_src_rdy_i), .f36_dst_rdy_o(le_f36_dst_rdy_o),
    .ll_data(le_ll_data), .ll_sof_n(le_ll_sof_n), .ll_eof_n(le_ll_eof_n),
    .ll_src_rdy_n(le_ll_src_rdy_n), .ll_dst_rdy_n(ll_dst_rdy_n), .err(le_err)
  );

  function automatic logic [35:0] mk(input logic [1:0] occ, input logic eof, input logic sof,
                                     input logic [31:0] d);
    return {occ, eof, sof, d};
  endfunction

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; f36_src_rdy_i = 1'b0; f36_data = '0; ll_dst_rdy_n = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (ll_src_rdy_n !== 1'b1) begin bad++; $display("FAIL reset_src_rdy_n got=%b want=1", ll_src_rdy_n); end
    total++; if (ll_sof_n !== 1'b1) begin bad++; $display("FAIL reset_sof_n got=%b want=1", ll_sof_n); end
    total++; if (ll_eof_n !== 1'b1) begin bad++; $display("FAIL reset_eof_n got=%b want=1", ll_eof_n); end
    total++; if (f36_dst_rdy_o !== 1'b1) begin bad++; $display("FAIL reset_dst_rdy got=%b want=1", f36_dst_rdy_o); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (le_ll_src_rdy_n !== 1'b1 || le_f36_dst_rdy_o !== 1'b1 || le_err !== 1'b0) begin
      bad++; $display("FAIL reset_le got=%b%b%b want=110", le_ll_src_rdy_n, le_f36_dst_rdy_o, le_err);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp [4];
    exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    f36_data = mk(2'd0, 1'b1, 1'b1, 32'hA1B2C3D4); f36_src_rdy_i = 1'b1; ll_dst_rdy_n = 1'b0;
    #1;
    total++; if (f36_dst_rdy_o !== 1'b1) begin bad++; $display("FAIL single_idle_rdy got=%b want=1", f36_dst_rdy_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) f36_src_rdy_i = 1'b0;
      total++; if (ll_src_rdy_n !== 1'b0 || ll_data !== exp[i]) begin
        bad++; $display("FAIL single_byte%0d got=%h/%b want=%h/0", i, ll_data, ll_src_rdy_n, exp[i]);
      end
      total++; if (ll_sof_n !== (i != 0) || ll_eof_n !== (i != 3)) begin
        bad++; $display("FAIL single_flags%0d got=%b%b want=%b%b", i, ll_sof_n, ll_eof_n, i != 0, i != 3);
      end
      total++; if (f36_dst_rdy_o !== (i == 3)) begin
        bad++; $display("FAIL single_dst_rdy%0d got=%b want=%b", i, f36_dst_rdy_o, i == 3);
      end
    end
    @(negedge clk);
    total++; if (ll_src_rdy_n !== 1'b1) begin bad++; $display("FAIL single_drained got=%b want=1", ll_src_rdy_n); end
  endtask

  // First word carries occ=1 with eof=0: occ must be ignored and all 4 bytes sent
  task automatic test_two_word();
    logic [7:0] exp [6];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    f36_data = mk(2'd1, 1'b0, 1'b1, 32'h11223344); f36_src_rdy_i = 1'b1; ll_dst_rdy_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) f36_data = mk(2'd2, 1'b1, 1'b0, 32'h55660000);
      if (k == 4) f36_src_rdy_i = 1'b0;
      total++; if (ll_src_rdy_n !== 1'b0 || ll_data !== exp[k]) begin
        bad++; $display("FAIL two_byte%0d got=%h/%b want=%h/0", k, ll_data, ll_src_rdy_n, exp[k]);
      end
      total++; if (ll_sof_n !== (k != 0) || ll_eof_n !== (k != 5)) begin
        bad++; $display("FAIL two_flags%0d got=%b%b want=%b%b", k, ll_sof_n, ll_eof_n, k != 0, k != 5);
      end
      total++; if (f36_dst_rdy_o !== (k == 3 || k == 5)) begin
        bad++; $display("FAIL two_dst_rdy%0d got=%b want=%b", k, f36_dst_rdy_o, k == 3 || k == 5);
      end
    end
    @(negedge clk);
    total++; if (ll_src_rdy_n !== 1'b1) begin bad++; $display("FAIL two_drained got=%b want=1", ll_src_rdy_n); end
  endtask

  task automatic test_stall();
    logic [7:0]  exp [4];
    logic [15:0] pat;
    int j;
    int cyc;
    exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    pat = 16'b0110_1001_1100_1010;
    f36_data = mk(2'd0, 1'b1, 1'b1, 32'hA1B2C3D4); f36_src_rdy_i = 1'b1; ll_dst_rdy_n = 1'b1;
    @(negedge clk);
    f36_src_rdy_i = 1'b0;
    j = 0; cyc = 0;
    while (j < 4 && cyc < 40) begin
      total++; if (ll_src_rdy_n !== 1'b0 || ll_data !== exp[j] || ll_sof_n !== (j != 0) || ll_eof_n !== (j != 3)) begin
        bad++; $display("FAIL stall_c%0d got=%h/%b%b%b want=%h/0%b%b", cyc, ll_data, ll_src_rdy_n,
                        ll_sof_n, ll_eof_n, exp[j], j != 0, j != 3);
      end
      ll_dst_rdy_n = pat[cyc % 16];
      @(negedge clk);
      if (!pat[cyc % 16]) j++;
      cyc++;
    end
    ll_dst_rdy_n = 1'b0;
    total++; if (j != 4) begin bad++; $display("FAIL stall_timeout got=%0d want=4", j); end
    total++; if (ll_src_rdy_n !== 1'b1) begin bad++; $display("FAIL stall_drained got=%b want=1", ll_src_rdy_n); end
  endtask

  task automatic test_little_endian();
    logic [7:0] exp [4];
    exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    f36_data = mk(2'd0, 1'b1, 1'b1, 32'hA1B2C3D4); f36_src_rdy_i = 1'b1; ll_dst_rdy_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) f36_src_rdy_i = 1'b0;
      total++; if (le_ll_src_rdy_n !== 1'b0 || le_ll_data !== exp[i] ||
                   le_ll_sof_n !== (i != 0) || le_ll_eof_n !== (i != 3)) begin
        bad++; $display("FAIL le_byte%0d got=%h/%b%b%b want=%h/0%b%b", i, le_ll_data, le_ll_src_rdy_n,
                        le_ll_sof_n, le_ll_eof_n, exp[i], i != 0, i != 3);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_partial();
    logic [7:0] exp [3];
    exp = '{8'h77, 8'h88, 8'h99};
    ll_dst_rdy_n = 1'b0;
    f36_data = mk(2'd1, 1'b1, 1'b1, 32'hEE000000); f36_src_rdy_i = 1'b1;
    @(negedge clk);
    f36_src_rdy_i = 1'b0;
    total++; if (ll_src_rdy_n !== 1'b0 || ll_data !== 8'hEE || ll_sof_n !== 1'b0 || ll_eof_n !== 1'b0) begin
      bad++; $display("FAIL occ1_byte got=%h/%b%b%b want=ee/000", ll_data, ll_src_rdy_n, ll_sof_n, ll_eof_n);
    end
    total++; if (f36_dst_rdy_o !== 1'b1) begin bad++; $display("FAIL occ1_dst_rdy got=%b want=1", f36_dst_rdy_o); end
    @(negedge clk);
    total++; if (ll_src_rdy_n !== 1'b1) begin bad++; $display("FAIL occ1_drained got=%b want=1", ll_src_rdy_n); end
    f36_data = mk(2'd3, 1'b1, 1'b1, 32'h778899AB); f36_src_rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) f36_src_rdy_i = 1'b0;
      total++; if (ll_src_rdy_n !== 1'b0 || ll_data !== exp[i] || ll_eof_n !== (i != 2)) begin
        bad++; $display("FAIL occ3_byte%0d got=%h/%b%b want=%h/0%b", i, ll_data, ll_src_rdy_n, ll_eof_n,
                        exp[i], i != 2);
      end
    end
    @(negedge clk);
    total++; if (ll_src_rdy_n !== 1'b1) begin bad++; $display("FAIL occ3_drained got=%b want=1", ll_src_rdy_n); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [4];
    exp = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    ll_dst_rdy_n = 1'b0;
    f36_data = mk(2'd0, 1'b1, 1'b1, 32'hA1B2C3D4); f36_src_rdy_i = 1'b1;
    @(negedge clk);
    f36_src_rdy_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (ll_src_rdy_n !== 1'b1 || ll_sof_n !== 1'b1 || ll_eof_n !== 1'b1 || f36_dst_rdy_o !== 1'b1) begin
      bad++; $display("FAIL rstmid_idle got=%b%b%b%b want=1111", ll_src_rdy_n, ll_sof_n, ll_eof_n, f36_dst_rdy_o);
    end
    f36_data = mk(2'd0, 1'b1, 1'b1, 32'h0A0B0C0D); f36_src_rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) f36_src_rdy_i = 1'b0;
      total++; if (ll_src_rdy_n !== 1'b0 || ll_data !== exp[i] || ll_sof_n !== (i != 0) || ll_eof_n !== (i != 3)) begin
        bad++; $display("FAIL rstmid_byte%0d got=%h/%b%b%b want=%h/0%b%b", i, ll_data, ll_src_rdy_n,
                        ll_sof_n, ll_eof_n, exp[i], i != 0, i != 3);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_err();
    logic exp_err;
`ifdef FIFO36_TO_LL8_ERR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    ll_dst_rdy_n = 1'b0;
    f36_data = mk(2'd0, 1'b0, 1'b1, 32'h01020304); f36_src_rdy_i = 1'b1;
    @(negedge clk);
    f36_src_rdy_i = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_first got=%b want=0", err); end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    f36_data = mk(2'd0, 1'b0, 1'b1, 32'h05060708); f36_src_rdy_i = 1'b1;
    @(negedge clk);
    f36_src_rdy_i = 1'b0;
    total++; if (err !== exp_err) begin bad++; $display("FAIL err_second got=%b want=%b", err, exp_err); end
    total++; if (ll_data !== 8'h05 || ll_sof_n !== 1'b0) begin
      bad++; $display("FAIL err_forward got=%h/%b want=05/0", ll_data, ll_sof_n);
    end
    @(negedge clk);
    @(negedge clk);
    total++; if (err !== exp_err) begin bad++; $display("FAIL err_sticky got=%b want=%b", err, exp_err); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", err); end
    total++; if (ll_src_rdy_n !== 1'b1 || f36_dst_rdy_o !== 1'b1) begin
      bad++; $display("FAIL clear_flush got=%b%b want=11", ll_src_rdy_n, f36_dst_rdy_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_two_word();
    test_stall();
    test_little_endian();
    test_partial();
    test_reset_mid();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
